// File: rtl/sms32_13_inv_seq_if.sv
// Valid/ready handshake bundle for the GF(2^6) inverse S-box engine.
// master drives requests and accepts results; slave is the engine itself.
interface sms32_13_inv_seq_if #(
    parameter int unsigned W = 6
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sms32_13_inv_seq.sv
// Inverse of the power-13 S-box: y = x^EXP in GF(2^W), one exponent bit per clock
// using left-to-right square-and-multiply.
module sms32_13_inv_seq #(
    parameter int unsigned  W     = 6,
    parameter logic [W-1:0] POLY  = 6'h03,
    parameter int unsigned  EXP   = 34,
    parameter int unsigned  EXP_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    sms32_13_inv_seq_if.slave  io,
    output logic               busy
);

    localparam int unsigned      IDX_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [EXP_W-1:0] EXP_BITS = EXP_W'(EXP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_W - 1);
    localparam logic [W-1:0]     ONE      = W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     base_q, base_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [W-1:0]     step;

    // Carry-less product, then fold the high terms back using x^W = POLY.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] p;
        p = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (b[i]) p[i +: W] = p[i +: W] ^ a;
        end
        for (int unsigned i = 2*W-2; i >= W; i--) begin
            if (p[i]) begin
                p[i]         = 1'b0;
                p[i-W +: W]  = p[i-W +: W] ^ POLY;
            end
        end
        return p[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        base_d     = base_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        step       = gf_mul(gf_mul(acc_q, acc_q), EXP_BITS[idx_q] ? base_q : ONE);
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    base_d  = io.in_data;
                    acc_d   = ONE;
                    idx_d   = IDX_LAST;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step;
                if (idx_q == '0) begin
                    out_data_d = step;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_q == IDLE);
        io.out_valid = (state_q == DONE);
        io.out_data  = out_data_q;
        busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sms32_13_inv_seq.sv
// Directed bench for sms32_13_inv_seq: reset, single ops, backpressure,
// exhaustive inverse of x^13, and streaming throughput.
module tb_sms32_13_inv_seq;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;

    sms32_13_inv_seq_if #(.W(6)) bus ();

    sms32_13_inv_seq #(
        .W     (6),
        .POLY  (6'h03),
        .EXP   (34),
        .EXP_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference field model: shift-and-add with xtime over x^6 + x + 1.
    function automatic logic [5:0] xtime(input logic [5:0] a);
        logic [5:0] r;
        r = {a[4:0], 1'b0};
        if (a[5]) r = r ^ 6'h03;
        return r;
    endfunction

    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r;
        logic [5:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ t;
            t = xtime(t);
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < e; i++) r = ref_mul(r, x);
        return r;
    endfunction

    task automatic run_op(input logic [5:0] x, output logic [5:0] y, output int lat);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = ~x;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) check("op_timeout", {31'd0, bus.out_valid}, 32'd1);
        y = bus.out_data;
        @(posedge clk); #1;
    endtask

    logic [5:0] y;
    logic [5:0] f;
    int         lat;
    logic [5:0] sin [20];
    int         nin, nout, cyc, last;
    logic       ir, ov;
    logic [5:0] od;

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_out_data",  {26'd0, bus.out_data},  32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single operations with hand-computed results
        run_op(6'h02, y, lat);
        check("op02_data", {26'd0, y}, 32'h24);
        check("op02_lat", lat, 6);
        check("op02_idle", {31'd0, bus.in_ready}, 32'd1);
        check("op02_hold", {26'd0, bus.out_data}, 32'h24);
        run_op(6'h00, y, lat);
        check("op00_data", {26'd0, y}, 32'h00);
        check("op00_lat", lat, 6);
        run_op(6'h01, y, lat);
        check("op01_data", {26'd0, y}, 32'h01);

        // Reset two cycles into RUN discards the operation
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'h02;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("mid_rst_busy",      {31'd0, busy},          32'd0);
        check("mid_rst_out_data",  {26'd0, bus.out_data},  32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            check("post_rst_no_result", {31'd0, bus.out_valid}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
        end
        run_op(6'h02, y, lat);
        check("post_rst_op02", {26'd0, y}, 32'h24);

        // Backpressure in DONE
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'h02;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", lat, 6);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_data",  {26'd0, bus.out_data},  32'h24);
            check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            bus.in_valid = (i == 3);
            bus.in_data  = 6'h05;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_done_ready", {31'd0, bus.in_ready},  32'd1);
        check("bp_done_busy",  {31'd0, busy},          32'd0);
        check("bp_done_data",  {26'd0, bus.out_data},  32'h24);
        @(posedge clk); #1;
        check("bp_no_ghost", {31'd0, busy}, 32'd0);

        // Exhaustive inverse of x^13
        for (int x = 0; x < 64; x++) begin
            f = ref_pow(6'(x), 13);
            run_op(f, y, lat);
            check("inv", {26'd0, y}, x);
            check("roundtrip", {26'd0, ref_pow(y, 13)}, {26'd0, f});
        end

        // Streaming with in_valid and out_ready held high
        for (int i = 0; i < 20; i++) sin[i] = 6'($urandom_range(0, 63));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = sin[0];
        nin = 0; nout = 0; cyc = 0; last = 0;
        while (nout < 20 && cyc < 300) begin
            ir = bus.in_ready;
            ov = bus.out_valid;
            od = bus.out_data;
            @(posedge clk); #1;
            cyc++;
            if (ir && bus.in_valid) begin
                nin++;
                if (nin < 20) bus.in_data = sin[nin];
                else          bus.in_valid = 1'b0;
            end
            if (ov) begin
                check("stream_data", {26'd0, od}, {26'd0, ref_pow(sin[nout], 34)});
                if (nout > 0) check("stream_gap", cyc - last, 8);
                last = cyc;
                nout++;
            end
        end
        check("stream_count", nout, 20);
        check("stream_in_count", nin, 20);
        repeat (10) begin
            @(posedge clk); #1;
            check("stream_no_extra", {31'd0, bus.out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
